mc_control_hs: RTL and testbench
================================

Name: mc_control_hs

Overview:
- Parametrised multi-cycle control FSM for the MIPS-subset core, successor to the fixed-latency controller.
- Adds a variable-latency memory handshake (req/ack) on fetch, load and store, a bounded ack timeout, and a sticky fault state for illegal opcodes or timeouts.
- Sits between the instruction register/ALU zero flag and the PC, register file, ALU and memory datapath controls.

Parameters:
- DATA_W, 32, instruction width, minimum 32; opcode = instr[DATA_W-1 -: 6].
- TIMEOUT, 15, maximum cycles spent waiting for mem_ack before fault, minimum 1.
- CNT_W, 16, width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- instr  in  DATA_W  current instruction register contents
- zero  in  1  ALU zero flag
- mem_ack  in  1  memory completion, sampled on rising clk
- mem_req  out  1  memory access request
- PC_en  out  1  PC write enable
- PC_sel  out  1  0 = PC+4, 1 = PC+imm
- MEMwr_en  out  1  store enable, valid while mem_req is high
- RFsel_wr  out  1  0 = ALU result, 1 = memory data
- RFsel_B  out  1  0 = $rt, 1 = $rd
- RFwr_en  out  1  register file write enable
- ALUsel_B  out  1  0 = RF operand B, 1 = immediate
- func  out  4  ALU operation
- fault  out  1  sticky fault indicator
- fault_code  out  2  01 = illegal opcode, 10 = timeout, 00 = none
- state_o  out  4  current state encoding (debug)

Behaviour:
- States and state_o encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_WR=3, MEM_RD=4, LD_WB=5, ALU_EXEC=6, ALU_WB=7, BRANCH=8, FAULT=9.
- Reset:
  - State returns to FETCH, wait counter clears, fault and fault_code clear.
  - Every output is 0 while reset is high; mem_req is gated by ~reset.
- Output style: Moore outputs decoded from the state, plus PC_en in FETCH, which is qualified by mem_ack.
- FETCH:
  - mem_req=1.
  - Holds until mem_ack=1. On the ack cycle, PC_en=1 and PC_sel=0, then go to DECODE.
- DECODE:
  - All-zero instr: nop, go to FETCH.
  - opcode[5]=0 and opcode[1:0]=11: go to MEM_ADDR.
  - opcode[5]=1 and opcode!=111111: go to ALU_EXEC.
  - opcode=111111 or opcode[5:1]=00000: go to BRANCH.
  - Anything else: go to FAULT with fault_code=01.
- MEM_ADDR:
  - ALUsel_B=1, RFsel_B=1, func=0000.
  - opcode 000111 or 011111 (store): go to MEM_WR. Otherwise go to MEM_RD.
- MEM_WR:
  - mem_req=1, MEMwr_en=1, ALUsel_B=1, RFsel_B=1, func=0000.
  - Holds until mem_ack, then go to FETCH.
- MEM_RD:
  - mem_req=1, RFsel_wr=1, ALUsel_B=1, RFsel_B=1, func=0000.
  - Holds until mem_ack, then go to LD_WB.
- LD_WB: RFwr_en=1, RFsel_wr=1, ALUsel_B=1, func=0000; go to FETCH.
- ALU_EXEC and ALU_WB:
  - opcode[4]=0 (R-type): RFsel_B=0, ALUsel_B=0, func=instr[3:0].
  - opcode[4]=1 (I-type): RFsel_B=1, ALUsel_B=1, func={0,opcode[2:0]}.
  - RFsel_wr=0 in both states; ALU_WB additionally sets RFwr_en=1.
  - ALU_EXEC goes to ALU_WB; ALU_WB goes to FETCH.
- BRANCH:
  - RFsel_B=1, ALUsel_B=0, func=0001.
  - taken = opcode[5] | (opcode[0]^zero). PC_en=taken, PC_sel=1.
  - Go to FETCH.
- Wait counter:
  - Clears on entry to FETCH, MEM_WR or MEM_RD.
  - Increments each cycle in those states while mem_ack=0.
  - When the counter equals TIMEOUT-1 and mem_ack=0, go to FAULT with fault_code=10.
  - If mem_ack=1 on that same cycle, the ack wins and no fault is raised.
- FAULT: all controls 0, fault=1. Stays in FAULT until reset.
- mem_ack outside a wait state is ignored.
- Reset asserted mid-access drops mem_req immediately (asynchronously).

Optional Feature:
- Macro: MC_CTRL_RETIRE_CNT_EN.
- With the macro defined:
  - Adds output retired_cnt [CNT_W-1:0], reset to 0.
  - Increments by 1 on every transition into FETCH from any state other than FETCH, including a nop from DECODE.
  - Wraps from all-ones to 0.
  - Does not increment when entering FAULT.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- add R-type (opcode 100000, instr[3:0]=0010), mem_ack after 2 wait cycles:
  - FETCH lasts 3 cycles with PC_en=1 only on the ack cycle.
  - Then DECODE, ALU_EXEC (func=0010, RFsel_B=0), ALU_WB (RFwr_en=1), back to FETCH.
- lw (opcode 000011) and sw (opcode 000111), each with mem_ack delayed 4 cycles:
  - lw visits MEM_RD for 5 cycles, then LD_WB with RFwr_en=1.
  - sw holds MEMwr_en=1 with mem_req=1 for 5 cycles; RFwr_en never asserts.
- beq (000000, nonzero instr):
  - zero=1: PC_en=1, PC_sel=1 in BRANCH.
  - zero=0: PC_en=0.
  - bne (000001) gives the inverse; b (111111) is always taken.
- Timeout:
  - mem_ack held low for TIMEOUT=15 cycles in FETCH: FAULT, fault_code=10, state_o=9.
  - mem_ack rising on cycle 15: no fault.
- Illegal opcode 010000: FAULT with fault_code=01, held until reset; reset clears fault and returns to FETCH.
- Retire counter (MC_CTRL_RETIRE_CNT_EN, CNT_W=4):
  - 17 retired nops give retired_cnt=1 (wrap).
  - Asserting reset mid-MEM_RD clears the counter and forces all outputs to 0 while reset is high.

Source files
------------

// File: rtl/mc_control_hs.sv
// mc_control_hs: multi-cycle control FSM for the MIPS-subset core.
// Variable-latency req/ack memory handshake on fetch, load and store,
// a bounded ack timeout, and a sticky fault state.
// Optional retired-instruction counter: define MC_CTRL_RETIRE_CNT_EN.
module mc_control_hs #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr,
  input  logic              zero,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              PC_en,
  output logic              PC_sel,
  output logic              MEMwr_en,
  output logic              RFsel_wr,
  output logic              RFsel_B,
  output logic              RFwr_en,
  output logic              ALUsel_B,
  output logic [3:0]        func,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [3:0]        state_o
`ifdef MC_CTRL_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retired_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_WR   = 4'd3,
    S_MEM_RD   = 4'd4,
    S_LD_WB    = 4'd5,
    S_ALU_EXEC = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_FAULT    = 4'd9
  } state_t;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        fault_code_r, fault_code_nxt;
  logic [5:0]        opcode;
  logic              timed_out;

  logic mem_req_c, pc_en_c, pc_sel_c, memwr_c, rfsel_wr_c;
  logic rfsel_b_c, rfwr_c, alusel_b_c;
  logic [3:0] func_c;

  assign opcode    = instr[DATA_W-1 -: 6];
  assign timed_out = (wait_cnt == WAIT_LAST) && !mem_ack;

  // State register, async active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Wait counter: cleared on any state change, counts idle cycles while waiting for ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt <= '0;
    else if (next_state != state) wait_cnt <= '0;
    else if (!mem_ack) wait_cnt <= wait_cnt + 1'b1;
  end

  // Fault cause is latched on entry to FAULT and held until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_code_r <= 2'b00;
    else if (state != S_FAULT && next_state == S_FAULT) fault_code_r <= fault_code_nxt;
  end

  // Next-state and Moore decode (PC_en in FETCH is qualified by mem_ack).
  always_comb begin
    next_state     = state;
    fault_code_nxt = 2'b00;
    mem_req_c      = 1'b0;
    pc_en_c        = 1'b0;
    pc_sel_c       = 1'b0;
    memwr_c        = 1'b0;
    rfsel_wr_c     = 1'b0;
    rfsel_b_c      = 1'b0;
    rfwr_c         = 1'b0;
    alusel_b_c     = 1'b0;
    func_c         = 4'b0000;
    case (state)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ack) begin
          pc_en_c    = 1'b1;
          next_state = S_DECODE;
        end else if (timed_out) begin
          next_state     = S_FAULT;
          fault_code_nxt = 2'b10;
        end
      end
      S_DECODE: begin
        if (instr == '0)                             next_state = S_FETCH;
        else if (!opcode[5] && opcode[1:0] == 2'b11) next_state = S_MEM_ADDR;
        else if (opcode[5] && opcode != 6'b111111)   next_state = S_ALU_EXEC;
        else if (opcode == 6'b111111 || opcode[5:1] == 5'b00000) next_state = S_BRANCH;
        else begin
          next_state     = S_FAULT;
          fault_code_nxt = 2'b01;
        end
      end
      S_MEM_ADDR: begin
        alusel_b_c = 1'b1;
        rfsel_b_c  = 1'b1;
        if (opcode == 6'b000111 || opcode == 6'b011111) next_state = S_MEM_WR;
        else                                            next_state = S_MEM_RD;
      end
      S_MEM_WR: begin
        mem_req_c  = 1'b1;
        memwr_c    = 1'b1;
        alusel_b_c = 1'b1;
        rfsel_b_c  = 1'b1;
        if (mem_ack) next_state = S_FETCH;
        else if (timed_out) begin
          next_state     = S_FAULT;
          fault_code_nxt = 2'b10;
        end
      end
      S_MEM_RD: begin
        mem_req_c  = 1'b1;
        rfsel_wr_c = 1'b1;
        alusel_b_c = 1'b1;
        rfsel_b_c  = 1'b1;
        if (mem_ack) next_state = S_LD_WB;
        else if (timed_out) begin
          next_state     = S_FAULT;
          fault_code_nxt = 2'b10;
        end
      end
      S_LD_WB: begin
        rfwr_c     = 1'b1;
        rfsel_wr_c = 1'b1;
        alusel_b_c = 1'b1;
        next_state = S_FETCH;
      end
      S_ALU_EXEC, S_ALU_WB: begin
        rfsel_b_c  = opcode[4];
        alusel_b_c = opcode[4];
        func_c     = opcode[4] ? {1'b0, opcode[2:0]} : instr[3:0];
        rfwr_c     = (state == S_ALU_WB);
        next_state = (state == S_ALU_EXEC) ? S_ALU_WB : S_FETCH;
      end
      S_BRANCH: begin
        rfsel_b_c  = 1'b1;
        func_c     = 4'b0001;
        pc_en_c    = opcode[5] | (opcode[0] ^ zero);
        pc_sel_c   = 1'b1;
        next_state = S_FETCH;
      end
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_FETCH;
    endcase
  end

  assign mem_req    = mem_req_c  & ~reset;
  assign PC_en      = pc_en_c    & ~reset;
  assign PC_sel     = pc_sel_c   & ~reset;
  assign MEMwr_en   = memwr_c    & ~reset;
  assign RFsel_wr   = rfsel_wr_c & ~reset;
  assign RFsel_B    = rfsel_b_c  & ~reset;
  assign RFwr_en    = rfwr_c     & ~reset;
  assign ALUsel_B   = alusel_b_c & ~reset;
  assign func       = reset ? 4'b0000 : func_c;
  assign fault      = (state == S_FAULT) & ~reset;
  assign fault_code = reset ? 2'b00 : fault_code_r;
  assign state_o    = reset ? 4'd0 : state;

`ifdef MC_CTRL_RETIRE_CNT_EN
  // Count every return to FETCH from another state; FAULT never returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retired_cnt <= '0;
    else if (next_state == S_FETCH && state != S_FETCH) retired_cnt <= retired_cnt + 1'b1;
  end
`else
  logic [CNT_W-1:0] unused_retire;
  assign unused_retire = '0;
`endif

endmodule

// File: tb/tb_mc_control_hs.sv
// Self-checking bench for mc_control_hs: a per-instruction behavioural model
// expands each instruction into its expected per-cycle control vectors.
module tb_mc_control_hs;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DATA_W-1:0] instr = '0;
  logic zero = 1'b0;
  logic mem_ack = 1'b0;
  logic mem_req, PC_en, PC_sel, MEMwr_en, RFsel_wr, RFsel_B, RFwr_en, ALUsel_B;
  logic [3:0] func;
  logic fault;
  logic [1:0] fault_code;
  logic [3:0] state_o;
`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_cnt;
`endif

  mc_control_hs #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .PC_en(PC_en), .PC_sel(PC_sel), .MEMwr_en(MEMwr_en),
    .RFsel_wr(RFsel_wr), .RFsel_B(RFsel_B), .RFwr_en(RFwr_en), .ALUsel_B(ALUsel_B),
    .func(func), .fault(fault), .fault_code(fault_code), .state_o(state_o)
`ifdef MC_CTRL_RETIRE_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [18:0] dut_vec;
  assign dut_vec = {state_o, mem_req, PC_en, PC_sel, MEMwr_en, RFsel_wr, RFsel_B,
                    RFwr_en, ALUsel_B, func, fault, fault_code};

  int checks = 0;
  int fails  = 0;
  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];
  bit          ack_q[$];
  bit model_faulted;
  int model_ret = 0;

  // {state, req, pc_en, pc_sel, wr, rfsel_wr, rfsel_b, rfwr, alusel_b, func, fault, code}
  function automatic logic [18:0] pk(input logic [3:0] st, input bit req, input bit pce,
      input bit pcs, input bit wr, input bit rws, input bit rfb, input bit rfw,
      input bit alb, input logic [3:0] fn, input bit flt, input logic [1:0] code);
    return {st, req, pce, pcs, wr, rws, rfb, rfw, alb, fn, flt, code};
  endfunction

  // 0 nop, 1 memory, 2 alu, 3 branch, 4 illegal
  function automatic int classify(input logic [31:0] ins);
    logic [5:0] o;
    o = ins[31:26];
    if (ins == 32'd0) return 0;
    if (!o[5] && o[1:0] == 2'b11) return 1;
    if (o[5] && o != 6'h3f) return 2;
    if (o == 6'h3f || o[5:1] == 5'd0) return 3;
    return 4;
  endfunction

  task automatic push(input logic [18:0] v, input bit a);
    exp_q.push_back(v);
    ack_q.push_back(a);
  endtask

  function automatic bit rnd_ack();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic model_fault(input logic [1:0] code);
    repeat (3) push(pk(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, code), rnd_ack());
    model_faulted = 1'b1;
  endtask

  // A waiting state: ack arrives on wait cycle d (0-based); no ack within TIMEOUT cycles faults.
  task automatic model_wait(input logic [3:0] st, input int d, output bit ok);
    bit a;
    for (int i = 0; i < TIMEOUT; i++) begin
      a = (i == d);
      case (st)
        4'd0:    push(pk(st, 1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00), a);
        4'd3:    push(pk(st, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 2'b00), a);
        default: push(pk(st, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 2'b00), a);
      endcase
      if (a) begin
        ok = 1'b1;
        return;
      end
    end
    ok = 1'b0;
    model_fault(2'b10);
  endtask

  task automatic model_instr(input logic [31:0] ins, input bit z, input int fd, input int md);
    logic [5:0] o;
    logic [3:0] fn;
    bit ok, it, tk;
    o = ins[31:26];
    model_faulted = 1'b0;
    model_wait(4'd0, fd, ok);
    if (!ok) return;
    push(pk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'b00), rnd_ack());
    case (classify(ins))
      1: begin
        push(pk(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 2'b00), rnd_ack());
        if (o == 6'b000111 || o == 6'b011111) model_wait(4'd3, md, ok);
        else begin
          model_wait(4'd4, md, ok);
          if (ok) push(pk(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 2'b00), rnd_ack());
        end
      end
      2: begin
        it = o[4];
        fn = it ? {1'b0, o[2:0]} : ins[3:0];
        push(pk(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, it, 1'b0, it, fn, 1'b0, 2'b00), rnd_ack());
        push(pk(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, it, 1'b1, it, fn, 1'b0, 2'b00), rnd_ack());
      end
      3: begin
        tk = o[5] | (o[0] ^ z);
        push(pk(4'd8, 1'b0, tk, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 2'b00), rnd_ack());
      end
      4: model_fault(2'b01);
      default: ;
    endcase
    if (!model_faulted) model_ret++;
  endtask

  // Called on a falling edge, returns on a falling edge; samples 1 time unit after driving.
  task automatic play(input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      mem_ack = ack_q[i];
      #1;
      obs_q.push_back(dut_vec);
      @(negedge clk);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    ack_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_ret = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ack = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 19'd0) begin
      fails++;
      $display("FAIL reset_outputs got %h exp %h", dut_vec, 19'd0);
    end
    mem_ack = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 19'd0) begin
      fails++;
      $display("FAIL reset_ack_gated got %h exp %h", dut_vec, 19'd0);
    end
`ifdef MC_CTRL_RETIRE_CNT_EN
    checks++;
    if (retired_cnt !== '0) begin
      fails++;
      $display("FAIL reset_retired got %0d exp 0", retired_cnt);
    end
`endif
    do_reset();
  endtask

  task automatic test_alu_add();
    clear_model();
    instr = {6'b100000, 22'd0, 4'b0010};
    model_instr(instr, 1'b0, 2, 0);
    play(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL alu_add[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_load_store();
    clear_model();
    instr = {6'b000011, 26'h0123456};
    model_instr(instr, 1'b0, 1, 4);
    play(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL lw[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    clear_model();
    instr = {6'b000111, 26'h0abcdef};
    model_instr(instr, 1'b0, 0, 4);
    play(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL sw[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops[5];
    bit zs[5];
    ops = '{6'b000000, 6'b000000, 6'b000001, 6'b000001, 6'b111111};
    zs  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int b = 0; b < 5; b++) begin
      clear_model();
      instr = {ops[b], 26'h0000040};
      zero  = zs[b];
      model_instr(instr, zs[b], 0, 0);
      play(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL branch%0d[%0d] got %h exp %h", b, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int delays[3];
    logic [31:0] ins[3];
    delays = '{TIMEOUT - 1, TIMEOUT, TIMEOUT};
    ins    = '{32'd0, 32'd0, {6'b000111, 26'd5}};
    for (int t = 0; t < 3; t++) begin
      clear_model();
      instr = ins[t];
      // third case times out in MEM_WR rather than FETCH
      if (t == 2) model_instr(ins[t], 1'b0, 0, TIMEOUT);
      else        model_instr(ins[t], 1'b0, delays[t], 0);
      play(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL timeout%0d[%0d] got %h exp %h", t, i, obs_q[i], exp_q[i]);
        end
      end
      if (model_faulted) do_reset();
    end
  endtask

  task automatic test_illegal();
    clear_model();
    instr = {6'b010000, 26'd9};
    model_instr(instr, 1'b0, 0, 0);
    play(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL illegal[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    do_reset();
    clear_model();
    instr = 32'd0;
    model_instr(instr, 1'b0, 0, 0);
    play(exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL after_fault_reset[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int r, fd, md;
    bit z;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      ins = $urandom();
      if (r == 0 || r == 9) ins = 32'd0;
      else if (r != 8) begin
        for (int k = 0; k < 100 && classify(ins) == 4; k++) ins = $urandom();
        if (classify(ins) == 4) ins = 32'd0;
      end
      z  = 1'($urandom_range(0, 1));
      fd = $urandom_range(0, 5);
      md = $urandom_range(0, 6);
      if ($urandom_range(0, 19) == 0) md = TIMEOUT - 1;
      if ($urandom_range(0, 29) == 0) md = TIMEOUT;
      clear_model();
      instr = ins;
      zero  = z;
      model_instr(ins, z, fd, md);
      play(exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          fails++;
          $display("FAIL random%0d[%0d] instr %h got %h exp %h", n, i, ins, obs_q[i], exp_q[i]);
        end
      end
`ifdef MC_CTRL_RETIRE_CNT_EN
      if (!model_faulted) begin
        checks++;
        if (retired_cnt !== CNT_W'(model_ret)) begin
          fails++;
          $display("FAIL random_retired%0d got %0d exp %0d", n, retired_cnt, CNT_W'(model_ret));
        end
      end
`endif
      if (model_faulted) do_reset();
    end
  endtask

  task automatic test_reset_mid_access();
    clear_model();
    instr = {6'b000011, 26'd77};
    model_instr(instr, 1'b0, 0, 10);
    // FETCH, DECODE, MEM_ADDR, then two cycles into MEM_RD
    play(5);
    reset = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 19'd0) begin
      fails++;
      $display("FAIL mid_rd_reset_async got %h exp %h", dut_vec, 19'd0);
    end
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== 19'd0) begin
      fails++;
      $display("FAIL mid_rd_reset_held got %h exp %h", dut_vec, 19'd0);
    end
`ifdef MC_CTRL_RETIRE_CNT_EN
    checks++;
    if (retired_cnt !== '0) begin
      fails++;
      $display("FAIL mid_rd_reset_retired got %0d exp 0", retired_cnt);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    model_ret = 0;
  endtask

  task automatic test_retire_wrap();
`ifdef MC_CTRL_RETIRE_CNT_EN
    do_reset();
    clear_model();
    instr = 32'd0;
    for (int n = 0; n < 17; n++) model_instr(32'd0, 1'b0, $urandom_range(0, 2), 0);
    play(exp_q.size());
    checks++;
    if (retired_cnt !== CNT_W'(model_ret) || model_ret != 17) begin
      fails++;
      $display("FAIL retire_wrap got %0d exp %0d", retired_cnt, CNT_W'(17));
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu_add();
    test_load_store();
    test_branch();
    test_timeout();
    test_illegal();
    test_random();
    test_reset_mid_access();
    test_retire_wrap();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
